// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: reset PC default, word size
// and the architectural PC read offset seen by decode.
package fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          WORD_BYTES       = 4;
  localparam int          PC_READ_OFFSET   = 8;

  // Queue depth doubles as the request credit pool and must wrap its pointers cleanly.
  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory and decode, plus a
// read-only debug view of the fetch stage's bookkeeping counters.
interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 3
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are
  // both high; valid never depends on ready. imem_rsp_valid has no ready and always
  // transfers. PCSrc is a one-cycle command, not a handshake.
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;

  logic              PCSrc;
  logic [ADDR_W-1:0] redirect_pc;

  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       Instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] instr_pc8;

  logic [ADDR_W-1:0] dbg_pc;
  logic [CNT_W-1:0]  dbg_outstanding;
  logic [CNT_W-1:0]  dbg_drop_cnt;
  logic [CNT_W-1:0]  dbg_count;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  PCSrc, redirect_pc,
    output instr_valid, Instr, instr_pc, instr_pc8,
    input  instr_ready,
    output dbg_pc, dbg_outstanding, dbg_drop_cnt, dbg_count
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output PCSrc, redirect_pc,
    input  instr_valid, Instr, instr_pc, instr_pc8,
    output instr_ready,
    input  dbg_pc, dbg_outstanding, dbg_drop_cnt, dbg_count
  );

endinterface

// File: rtl/fetch_fifo.sv
// In-order instruction queue: synchronous FIFO with push/pop/flush and an
// occupancy count. Flush wins over push and pop in the same cycle.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           head_data,
  output logic                       head_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != '0);
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word reads, queues
// returned words in order and squashes wrong-path work on a PCSrc redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int                CNT_W        = $clog2(DEPTH + 1);
  localparam int                ENTRY_W      = 32 + ADDR_W;
  localparam logic [ADDR_W-1:0] PC_STEP      = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] PC_READ_OFF  = ADDR_W'(PC_READ_OFFSET);
  localparam logic [CNT_W:0]    CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);
  localparam bit                DEPTH_OK     = is_pow2(DEPTH);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_valid;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ENTRY_W-1:0] fifo_push_data;
  logic [CNT_W:0]     in_flight;
  logic [ADDR_W-1:0]  redirect_aligned;
  logic               req_valid;
  logic               issue;
  logic               rsp_drop;
  logic               push;
  logic               pop;
  logic               head_valid;

  assign redirect_aligned = {bus.redirect_pc[ADDR_W-1:2], 2'b00};

  // Every request owns a queue slot from issue until decode pops it, so the
  // queue can never overflow.
  assign in_flight = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign req_valid = !reset && !bus.PCSrc && (in_flight < CREDIT_LIMIT);
  assign issue     = req_valid && bus.imem_req_ready;

  assign rsp_drop       = (drop_cnt_q != '0) || bus.PCSrc;
  assign push           = bus.imem_rsp_valid && !rsp_drop;
  assign fifo_push_data = {bus.imem_rsp_data, resp_pc_q};

  assign head_valid = fifo_valid && !reset;
  assign pop        = head_valid && bus.instr_ready;

  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q - CNT_W'(bus.imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q;
    if (bus.PCSrc) begin
      // Everything still in memory belongs to the old path; recount, never accumulate.
      pc_d       = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      drop_cnt_d = outstanding_d;
    end else begin
      if (issue) begin
        pc_d          = pc_q + PC_STEP;
        outstanding_d = outstanding_d + CNT_W'(1);
      end
      if (bus.imem_rsp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (bus.PCSrc),
    .push_data  (fifo_push_data),
    .head_data  (fifo_head),
    .head_valid (fifo_valid),
    .count      (fifo_count)
  );

  assign bus.imem_req_valid  = req_valid;
  assign bus.imem_req_addr   = pc_q;
  assign bus.instr_valid     = head_valid;
  assign bus.Instr           = fifo_head[ENTRY_W-1:ADDR_W];
  assign bus.instr_pc        = fifo_head[ADDR_W-1:0];
  assign bus.instr_pc8       = fifo_head[ADDR_W-1:0] + PC_READ_OFF;

  assign bus.dbg_pc          = pc_q;
  assign bus.dbg_outstanding = outstanding_q;
  assign bus.dbg_drop_cnt    = drop_cnt_q;
  assign bus.dbg_count       = fifo_count;

  a_depth_pow2: assert property (@(posedge clk) DEPTH_OK);
  a_credit: assert property (@(posedge clk) disable iff (reset) in_flight <= CREDIT_LIMIT);
  a_drop_le_out: assert property (@(posedge clk) disable iff (reset) drop_cnt_q <= outstanding_q);
  a_pc_aligned: assert property (@(posedge clk) disable iff (reset)
    !head_valid || (bus.instr_pc[1:0] == 2'b00));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with configurable latency, an
// expected-instruction-stream scoreboard, table vectors and redirect/reset corners.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          DEPTH  = 4;
  localparam int          ADDR_W = 32;
  localparam int          CNT_W  = $clog2(DEPTH + 1);
  localparam int          SB_W   = 64;
  localparam logic [31:0] RST_PC = 32'h0;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  fetch_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", 0);
    $fatal(1);
  end

  // ---------------- models / scoreboard state ----------------
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t           mem_q[$];
  logic [SB_W-1:0] exp_q[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  bit          rst_drive = 1'b1;
  int          n_issue = 0;
  int          n_pop = 0;
  logic [31:0] issue_pc = RST_PC;
  logic [31:0] next_pc = RST_PC;

  logic              s_rsp, s_req_valid, s_iv;
  logic [31:0]       s_req_addr, s_instr, s_ipc, s_ipc8, s_dbg_pc;
  logic [CNT_W-1:0]  s_dbg_out, s_dbg_drop, s_dbg_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {~addr[15:0], addr[15:0]} ^ 32'h5A5A_0000 ^ {16'h0, addr[31:16]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // After reset or a redirect to T, decode must see T, T+4, T+8, ... and nothing else.
  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    next_pc  = pc;
    issue_pc = pc;
  endtask

  task automatic sb_pop();
    logic [SB_W-1:0] e;
    if (exp_q.size() == 0) begin
      exp_q.push_back({mem_word(next_pc), next_pc});
      next_pc = next_pc + 32'd4;
    end
    e = exp_q.pop_front();
    check("instr_pc", {32'h0, s_ipc}, {32'h0, e[31:0]});
    check("Instr", {32'h0, s_instr}, {32'h0, e[63:32]});
    check("instr_pc8", {32'h0, s_ipc8}, {32'h0, e[31:0] + 32'd8});
    n_pop++;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic tick(input bit pcsrc, input logic [31:0] tgt, input bit iready, input bit rready);
    @(posedge clk);
    #1;
    cyc++;
    reset               = rst_drive;
    bus.PCSrc           = pcsrc;
    bus.redirect_pc     = tgt;
    bus.instr_ready     = iready;
    bus.imem_req_ready  = rready;
    s_rsp = 1'b0;
    if (rst_drive) mem_q.delete();
    else if (mem_q.size() > 0 && mem_q[0].due <= cyc) s_rsp = 1'b1;
    bus.imem_rsp_valid = s_rsp;
    if (s_rsp) bus.imem_rsp_data = mem_word(mem_q[0].addr);
    else       bus.imem_rsp_data = $urandom();
    #1;
    s_req_valid = bus.imem_req_valid;
    s_req_addr  = bus.imem_req_addr;
    s_iv        = bus.instr_valid;
    s_instr     = bus.Instr;
    s_ipc       = bus.instr_pc;
    s_ipc8      = bus.instr_pc8;
    s_dbg_pc    = bus.dbg_pc;
    s_dbg_out   = bus.dbg_outstanding;
    s_dbg_drop  = bus.dbg_drop_cnt;
    s_dbg_cnt   = bus.dbg_count;
    if (rst_drive) begin
      check("rst_req_valid", {63'h0, s_req_valid}, 64'h0);
      check("rst_instr_valid", {63'h0, s_iv}, 64'h0);
      sb_restart(RST_PC);
    end else begin
      if (s_rsp) void'(mem_q.pop_front());
      if (pcsrc) begin
        check("redir_req_valid", {63'h0, s_req_valid}, 64'h0);
        sb_restart({tgt[31:2], 2'b00});
      end else begin
        if (s_req_valid) begin
          check("req_addr", {32'h0, s_req_addr}, {32'h0, issue_pc});
          if (rready) begin
            mem_q.push_back('{addr: s_req_addr, due: cyc + mem_lat});
            issue_pc = issue_pc + 32'd4;
            n_issue++;
          end
        end
        if (s_iv && iready) sb_pop();
      end
    end
  endtask

  task automatic apply_reset(input int n);
    rst_drive = 1'b1;
    for (int i = 0; i < n; i++) tick(1'b0, $urandom(), 1'b0, 1'b1);
    rst_drive = 1'b0;
    n_issue = 0;
    n_pop   = 0;
  endtask

  task automatic run(input int n, input bit iready);
    for (int i = 0; i < n; i++) tick(1'b0, $urandom(), iready, 1'b1);
  endtask

  task automatic wait_valid(input string name, input int max_cyc);
    bit found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      tick(1'b0, $urandom(), 1'b0, 1'b1);
      if (s_iv) found = 1'b1;
    end
    check({name, "_timeout"}, {63'h0, found}, 64'h1);
  endtask

  // ---------------- table vectors: 1-cycle memory from reset ----------------
  typedef struct { bit iready; bit rv; logic [31:0] ra; bit iv; logic [31:0] ipc; } vec_t;
  localparam int NV = 14;
  vec_t vec[NV];

  initial begin
    vec[0]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    vec[1]  = '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
    vec[2]  = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
    vec[3]  = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd4};
    vec[4]  = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd8};
    vec[5]  = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd12};
    vec[6]  = '{1'b0, 1'b1, 32'd24, 1'b1, 32'd16};
    vec[7]  = '{1'b0, 1'b1, 32'd28, 1'b1, 32'd16};
    vec[8]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd16};
    vec[9]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd16};
    vec[10] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd16};
    vec[11] = '{1'b1, 1'b1, 32'd32, 1'b1, 32'd20};
    vec[12] = '{1'b1, 1'b1, 32'd36, 1'b1, 32'd24};
    vec[13] = '{1'b1, 1'b1, 32'd40, 1'b1, 32'd28};

    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.PCSrc          = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;

    // Streaming, stall and resume with exact cycle-by-cycle outputs.
    mem_lat = 1;
    apply_reset(2);
    for (int i = 0; i < NV; i++) begin
      tick(1'b0, $urandom(), vec[i].iready, 1'b1);
      check("t1_req_valid", {63'h0, s_req_valid}, {63'h0, vec[i].rv});
      if (vec[i].rv) check("t1_req_addr", {32'h0, s_req_addr}, {32'h0, vec[i].ra});
      check("t1_instr_valid", {63'h0, s_iv}, {63'h0, vec[i].iv});
      if (vec[i].iv) check("t1_instr_pc", {32'h0, s_ipc}, {32'h0, vec[i].ipc});
    end

    // Decode stalled from reset: credit stops issue at DEPTH requests.
    apply_reset(2);
    run(10, 1'b0);
    check("t2_issued", 64'(n_issue), 64'(DEPTH));
    check("t2_req_valid_stalled", {63'h0, s_req_valid}, 64'h0);
    run(10, 1'b1);
    check("t2_drained", {63'h0, n_pop >= DEPTH}, 64'h1);

    // 3-cycle memory, redirect with three requests in flight.
    mem_lat = 3;
    apply_reset(2);
    run(3, 1'b1);
    tick(1'b1, 32'h100, 1'b1, 1'b1);
    tick(1'b0, $urandom(), 1'b1, 1'b1);
    check("t3_drop_cnt", 64'(s_dbg_drop), 64'd2);
    check("t3_outstanding", 64'(s_dbg_out), 64'd2);
    wait_valid("t3_first", 20);
    check("t3_first_pc", {32'h0, s_ipc}, 64'h100);
    check("t3_first_instr", {32'h0, s_instr}, {32'h0, mem_word(32'h100)});
    run(12, 1'b1);

    // Redirect coinciding with a response and a pop.
    mem_lat = 2;
    apply_reset(2);
    run(4, 1'b1);
    tick(1'b1, 32'h40, 1'b1, 1'b1);
    check("t4_rsp_present", {63'h0, s_rsp}, 64'h1);
    check("t4_head_present", {63'h0, s_iv}, 64'h1);
    tick(1'b0, $urandom(), 1'b1, 1'b1);
    check("t4_instr_valid", {63'h0, s_iv}, 64'h0);
    check("t4_count", 64'(s_dbg_cnt), 64'd0);
    check("t4_drop_cnt", 64'(s_dbg_drop), 64'd1);
    check("t4_outstanding", 64'(s_dbg_out), 64'd1);
    run(15, 1'b1);

    // Back-to-back redirects: only the second path survives.
    tick(1'b1, 32'h200, 1'b1, 1'b1);
    tick(1'b1, 32'h300, 1'b1, 1'b1);
    wait_valid("t5_first", 20);
    check("t5_first_pc", {32'h0, s_ipc}, 64'h300);
    run(15, 1'b1);

    // Address wrap through zero, with unaligned target bits ignored.
    tick(1'b1, 32'hFFFF_FFFB, 1'b1, 1'b1);
    n_pop = 0;
    run(15, 1'b1);
    check("wrap_progress", {63'h0, n_pop >= 4}, 64'h1);

    // Reset with queued words and two requests outstanding.
    mem_lat = 3;
    apply_reset(2);
    run(5, 1'b0);
    rst_drive = 1'b1;
    tick(1'b0, $urandom(), 1'b0, 1'b1);
    check("t6_pre_outstanding", 64'(s_dbg_out), 64'd2);
    check("t6_pre_count", 64'(s_dbg_cnt), 64'd2);
    rst_drive = 1'b0;
    tick(1'b0, $urandom(), 1'b0, 1'b1);
    check("t6_instr_valid", {63'h0, s_iv}, 64'h0);
    check("t6_pc", {32'h0, s_dbg_pc}, {32'h0, RST_PC});
    check("t6_req_valid", {63'h0, s_req_valid}, 64'h1);
    wait_valid("t6_first", 20);
    check("t6_first_pc", {32'h0, s_ipc}, {32'h0, RST_PC});

    // Randomised traffic: latency, back-pressure, redirects and occasional resets.
    mem_lat = 1;
    apply_reset(1);
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] tgt;
      if (i % 300 == 0) mem_lat = $urandom_range(1, 3);
      rst_drive = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                            tgt = $urandom();
      tick($urandom_range(0, 15) == 0, tgt, $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0);
    end
    rst_drive = 1'b0;
    n_pop = 0;
    run(40, 1'b1);
    check("random_drain_progress", {63'h0, n_pop >= 20}, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
